// File: rtl/timer_phase_sequencer.sv
// Sequences one autoreset counter through four programmable timed phases,
// with shadowed limit registers, one-shot or looping operation and abort.
module timer_phase_sequencer #(
    parameter int unsigned W        = 8,
    parameter int unsigned N_PHASES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         stop,
    input  logic         loop,
    input  logic         cfg_we,
    input  logic [1:0]   cfg_addr,
    input  logic [W-1:0] cfg_data,
    input  logic         cnt_autoreset,
    output logic         cnt_rst,
    output logic         cnt_en,
    output logic [W-1:0] cnt_limit,
    output logic [1:0]   phase,
    output logic         busy,
    output logic         phase_done,
    output logic         cycle_done
);

    localparam int unsigned PW = 2;
    localparam logic [PW-1:0] LAST_PHASE = PW'(N_PHASES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                       state;
    state_t                       state_nx;
    logic [N_PHASES-1:0][W-1:0]   cfg;
    logic [N_PHASES-1:0][W-1:0]   shadow;
    logic [N_PHASES-1:0][W-1:0]   shadow_nx;
    logic [PW-1:0]                phase_nx;
    logic                         copy;
    logic                         phase_done_nx;
    logic                         cycle_done_nx;
    logic [W-1:0]                 limit_nx;

    // State register plus the registered Moore decodes of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            phase      <= '0;
            busy       <= 1'b0;
            phase_done <= 1'b0;
            cycle_done <= 1'b0;
            cnt_en     <= 1'b0;
            cnt_rst    <= 1'b1;
            cnt_limit  <= '0;
            shadow     <= '0;
        end else begin
            state      <= state_nx;
            phase      <= phase_nx;
            busy       <= (state_nx != IDLE);
            phase_done <= phase_done_nx;
            cycle_done <= cycle_done_nx;
            cnt_en     <= (state_nx == RUN);
            cnt_rst    <= (state_nx != RUN);
            cnt_limit  <= limit_nx;
            shadow     <= shadow_nx;
        end
    end

    // Config writes land in cfg only; shadow sees them at the next copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg <= '0;
        end else if (cfg_we) begin
            cfg[cfg_addr] <= cfg_data;
        end
    end

    always_comb begin
        state_nx      = state;
        phase_nx      = phase;
        copy          = 1'b0;
        phase_done_nx = 1'b0;
        cycle_done_nx = 1'b0;

        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_nx = LOAD;
                    phase_nx = '0;
                    copy     = 1'b1;
                end
            end
            LOAD: begin
                if (stop) begin
                    state_nx = IDLE;
                    phase_nx = '0;
                end else begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                // stop wins over a completing phase
                if (stop) begin
                    state_nx = IDLE;
                    phase_nx = '0;
                end else if (cnt_autoreset) begin
                    phase_done_nx = 1'b1;
                    if (phase == LAST_PHASE) begin
                        cycle_done_nx = 1'b1;
                        phase_nx      = '0;
                        if (loop) begin
                            state_nx = LOAD;
                            copy     = 1'b1;
                        end else begin
                            state_nx = IDLE;
                        end
                    end else begin
                        phase_nx = phase + PW'(1);
                        state_nx = LOAD;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                phase_nx = '0;
            end
        endcase

        shadow_nx = copy ? cfg : shadow;
        limit_nx  = shadow_nx[phase_nx];
    end

endmodule

// File: tb/tb_timer_phase_sequencer.sv
// Scoreboarded bench for timer_phase_sequencer driving a behavioural model
// of the autoreset counter; expected done pulses are queued per run.
module tb_timer_phase_sequencer;

    localparam int unsigned W = 8;

    typedef struct {
        int unsigned  at;
        logic         cd;
        logic [1:0]   ph;
        logic         bz;
        logic [W-1:0] lim;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic         stop;
    logic         loop;
    logic         cfg_we;
    logic [1:0]   cfg_addr;
    logic [W-1:0] cfg_data;
    logic         cnt_autoreset;
    logic         cnt_rst;
    logic         cnt_en;
    logic [W-1:0] cnt_limit;
    logic [1:0]   phase;
    logic         busy;
    logic         phase_done;
    logic         cycle_done;

    logic [W-1:0] cval;
    logic         ar_model;
    logic         ar_force;
    int unsigned  cyc = 0;
    int           tests = 0;
    int           fails = 0;
    exp_t         sb[$];

    timer_phase_sequencer #(.W(W), .N_PHASES(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .stop          (stop),
        .loop          (loop),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_data      (cfg_data),
        .cnt_autoreset (cnt_autoreset),
        .cnt_rst       (cnt_rst),
        .cnt_en        (cnt_en),
        .cnt_limit     (cnt_limit),
        .phase         (phase),
        .busy          (busy),
        .phase_done    (phase_done),
        .cycle_done    (cycle_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference autoreset counter: clear on rst, count on en, wrap at limit.
    always @(posedge clk) begin
        if (cnt_rst === 1'b1) begin
            cval     <= '0;
            ar_model <= 1'b0;
        end else if (cnt_en === 1'b1) begin
            if (cval >= cnt_limit) begin
                cval     <= '0;
                ar_model <= 1'b1;
            end else begin
                cval     <= cval + 8'd1;
                ar_model <= 1'b0;
            end
        end else begin
            ar_model <= 1'b0;
        end
    end

    assign cnt_autoreset = ar_model | ar_force;

    // Scoreboard: every done pulse must match the head of the queue.
    always @(negedge clk) begin
        if (rst === 1'b0 && phase_done === 1'b1) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL spurious_phase_done at cycle %0d (phase=%0d cd=%0b)", cyc, phase, cycle_done);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (cyc !== e.at || cycle_done !== e.cd || phase !== e.ph || busy !== e.bz || cnt_limit !== e.lim) begin
                    fails++;
                    $display("FAIL done_pulse got at=%0d cd=%0b ph=%0d busy=%0b lim=%0d, required at=%0d cd=%0b ph=%0d busy=%0b lim=%0d",
                             cyc, cycle_done, phase, busy, cnt_limit, e.at, e.cd, e.ph, e.bz, e.lim);
                end
            end
        end else if (rst === 1'b0 && cycle_done === 1'b1) begin
            tests++;
            fails++;
            $display("FAIL lone_cycle_done at cycle %0d", cyc);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic write_cfg(input logic [1:0] a, input logic [W-1:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic push(input int unsigned at, input logic cd, input logic [1:0] ph,
                        input logic bz, input logic [W-1:0] lim);
        exp_t e;
        e.at = at; e.cd = cd; e.ph = ph; e.bz = bz; e.lim = lim;
        sb.push_back(e);
    endtask

    // Pulse start for one cycle; t0 is the cycle count in the first LOAD cycle.
    task automatic do_start(output int unsigned t0);
        start = 1'b1;
        tick();
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_empty(input int budget, output bit ok);
        for (int i = 0; i < budget && sb.size() != 0; i++) tick();
        ok = (sb.size() == 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        tests++;
        if ({busy, phase, cnt_rst, cnt_en} !== {1'b0, 2'd0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL reset_ctrl got busy=%0b phase=%0d cnt_rst=%0b cnt_en=%0b, required 0 0 1 0",
                     busy, phase, cnt_rst, cnt_en);
        end
        tests++;
        if ({cnt_limit, phase_done, cycle_done} !== {8'd0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_out got lim=%0d pd=%0b cd=%0b, required 0 0 0", cnt_limit, phase_done, cycle_done);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_one_shot();
        int unsigned t0;
        bit ok;
        write_cfg(2'd0, 8'd2); write_cfg(2'd1, 8'd0);
        write_cfg(2'd2, 8'd5); write_cfg(2'd3, 8'd1);
        loop = 1'b0;
        do_start(t0);
        tests++;
        if ({busy, phase, cnt_limit, cnt_rst, cnt_en} !== {1'b1, 2'd0, 8'd2, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL one_shot_load got busy=%0b ph=%0d lim=%0d rst=%0b en=%0b, required 1 0 2 1 0",
                     busy, phase, cnt_limit, cnt_rst, cnt_en);
        end
        push(t0 + 5,  1'b0, 2'd1, 1'b1, 8'd0);
        push(t0 + 8,  1'b0, 2'd2, 1'b1, 8'd5);
        push(t0 + 16, 1'b0, 2'd3, 1'b1, 8'd1);
        push(t0 + 20, 1'b1, 2'd0, 1'b0, 8'd2);
        tick();
        tests++;
        if ({cnt_rst, cnt_en} !== 2'b01) begin
            fails++;
            $display("FAIL one_shot_run got rst=%0b en=%0b, required 0 1", cnt_rst, cnt_en);
        end
        wait_empty(40, ok);
        tests++;
        if (!ok || busy !== 1'b0) begin
            fails++;
            $display("FAIL one_shot_end got pending=%0d busy=%0b, required 0 0", sb.size(), busy);
        end
        sb.delete();
        tick();
    endtask

    task automatic test_loop();
        int unsigned t0;
        bit ok;
        for (int a = 0; a < 4; a++) write_cfg(2'(a), 8'd1);
        loop = 1'b1;
        do_start(t0);
        for (int k = 1; k <= 16; k++)
            push(t0 + 32'(4 * k), (k % 4) == 0, 2'(k % 4), k != 16, 8'd1);
        for (int i = 0; i < 100 && cyc != t0 + 48; i++) tick();
        tests++;
        if (cyc != t0 + 48 || busy !== 1'b1) begin
            fails++;
            $display("FAIL loop_3_periods got cycle=%0d busy=%0b, required %0d 1", cyc, busy, t0 + 48);
        end
        loop = 1'b0;
        wait_empty(40, ok);
        tests++;
        if (!ok || busy !== 1'b0) begin
            fails++;
            $display("FAIL loop_exit got pending=%0d busy=%0b, required 0 0", sb.size(), busy);
        end
        sb.delete();
        tick();
    endtask

    task automatic test_abort();
        int unsigned t0;
        write_cfg(2'd0, 8'd10);
        do_start(t0);
        for (int i = 0; i < 30 && cnt_autoreset !== 1'b1; i++) tick();
        tests++;
        if (cyc != t0 + 12) begin
            fails++;
            $display("FAIL abort_ar_timing got cycle=%0d, required %0d", cyc, t0 + 12);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tests++;
        if ({busy, phase, cnt_rst, cnt_en, phase_done, cycle_done} !== {1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL abort got busy=%0b ph=%0d rst=%0b en=%0b pd=%0b cd=%0b, required 0 0 1 0 0 0",
                     busy, phase, cnt_rst, cnt_en, phase_done, cycle_done);
        end
        repeat (2) tick();
    endtask

    task automatic test_shadow();
        int unsigned t0;
        bit ok;
        write_cfg(2'd0, 8'd0); write_cfg(2'd1, 8'd7);
        write_cfg(2'd2, 8'd0); write_cfg(2'd3, 8'd0);
        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_data = 8'd4;
        do_start(t0);
        cfg_we = 1'b0;
        push(t0 + 3,  1'b0, 2'd1, 1'b1, 8'd7);
        push(t0 + 13, 1'b0, 2'd2, 1'b1, 8'd0);
        push(t0 + 16, 1'b0, 2'd3, 1'b1, 8'd0);
        push(t0 + 19, 1'b1, 2'd0, 1'b0, 8'd0);
        wait_empty(40, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL shadow_old_run got pending=%0d, required 0", sb.size());
        end
        sb.delete();
        tick();
        do_start(t0);
        push(t0 + 3,  1'b0, 2'd1, 1'b1, 8'd4);
        push(t0 + 10, 1'b0, 2'd2, 1'b1, 8'd0);
        push(t0 + 13, 1'b0, 2'd3, 1'b1, 8'd0);
        push(t0 + 16, 1'b1, 2'd0, 1'b0, 8'd0);
        wait_empty(40, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL shadow_new_run got pending=%0d, required 0", sb.size());
        end
        sb.delete();
        tick();
    endtask

    task automatic test_ignored();
        int unsigned t0;
        bit ok;
        ar_force = 1'b1;
        tick();
        ar_force = 1'b0;
        tests++;
        if ({busy, phase, cnt_rst} !== {1'b0, 2'd0, 1'b1}) begin
            fails++;
            $display("FAIL ar_in_idle got busy=%0b ph=%0d rst=%0b, required 0 0 1", busy, phase, cnt_rst);
        end
        do_start(t0);
        ar_force = 1'b1;
        push(t0 + 3,  1'b0, 2'd1, 1'b1, 8'd4);
        push(t0 + 10, 1'b0, 2'd2, 1'b1, 8'd0);
        push(t0 + 13, 1'b0, 2'd3, 1'b1, 8'd0);
        push(t0 + 16, 1'b1, 2'd0, 1'b0, 8'd0);
        tick();
        ar_force = 1'b0;
        tests++;
        if ({busy, phase, cnt_en, cnt_rst} !== {1'b1, 2'd0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL ar_in_load got busy=%0b ph=%0d en=%0b rst=%0b, required 1 0 1 0",
                     busy, phase, cnt_en, cnt_rst);
        end
        for (int i = 0; i < 20 && cyc != t0 + 5; i++) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tests++;
        if ({busy, phase, cnt_en} !== {1'b1, 2'd1, 1'b1}) begin
            fails++;
            $display("FAIL start_in_run got busy=%0b ph=%0d en=%0b, required 1 1 1", busy, phase, cnt_en);
        end
        wait_empty(40, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL ignored_run got pending=%0d, required 0", sb.size());
        end
        sb.delete();
        tick();
    endtask

    task automatic test_long_phase();
        int unsigned t0;
        bit ok;
        write_cfg(2'd0, 8'd255); write_cfg(2'd1, 8'd0);
        do_start(t0);
        push(t0 + 258, 1'b0, 2'd1, 1'b1, 8'd0);
        push(t0 + 261, 1'b0, 2'd2, 1'b1, 8'd0);
        push(t0 + 264, 1'b0, 2'd3, 1'b1, 8'd0);
        push(t0 + 267, 1'b1, 2'd0, 1'b0, 8'd255);
        wait_empty(300, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL long_phase got pending=%0d, required 0", sb.size());
        end
        sb.delete();
        tick();
    endtask

    task automatic test_reset_midrun();
        int unsigned t0;
        bit ok;
        write_cfg(2'd0, 8'd6);
        do_start(t0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if ({busy, phase, cnt_rst, cnt_en, cnt_limit} !== {1'b0, 2'd0, 1'b1, 1'b0, 8'd0}) begin
            fails++;
            $display("FAIL reset_midrun got busy=%0b ph=%0d rst=%0b en=%0b lim=%0d, required 0 0 1 0 0",
                     busy, phase, cnt_rst, cnt_en, cnt_limit);
        end
        tick();
        // cfg was cleared too, so every phase is the minimum 3 cycles
        do_start(t0);
        push(t0 + 3,  1'b0, 2'd1, 1'b1, 8'd0);
        push(t0 + 6,  1'b0, 2'd2, 1'b1, 8'd0);
        push(t0 + 9,  1'b0, 2'd3, 1'b1, 8'd0);
        push(t0 + 12, 1'b1, 2'd0, 1'b0, 8'd0);
        wait_empty(30, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL reset_cfg_cleared got pending=%0d, required 0", sb.size());
        end
        sb.delete();
        tick();
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        loop     = 1'b0;
        cfg_we   = 1'b0;
        cfg_addr = 2'd0;
        cfg_data = '0;
        ar_force = 1'b0;
        test_reset();
        test_one_shot();
        test_loop();
        test_abort();
        test_shadow();
        test_ignored();
        test_long_phase();
        test_reset_midrun();
        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
